// File: rtl/clas_bist_engine_if.sv
// Operand/result bus between the BIST engine (master) and the 32-bit
// carry-look-ahead adder/subtractor it exercises (slave).
interface clas_bist_engine_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_sel;
    logic [WIDTH-1:0] dut_result;
    logic             dut_c_out;

    // No valid/ready pair on this bus: operands are held stable by the engine
    // for SETTLE_CYCLES, and the result is sampled in the following CHECK cycle.
    modport master (
        output dut_a, dut_b, dut_sel,
        input  dut_result, dut_c_out
    );

    modport slave (
        input  dut_a, dut_b, dut_sel,
        output dut_result, dut_c_out
    );
endinterface

// File: rtl/clas_bist_engine.sv
// On-chip self-test initiator for the carry-look-ahead adder/subtractor:
// corner vectors then LFSR vectors, add pass followed by subtract pass.
module clas_bist_engine #(
    parameter int               WIDTH         = 32,
    parameter int               NUM_VECTORS   = 1024,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [WIDTH-1:0] SEED_A        = 'h1,
    parameter logic [WIDTH-1:0] SEED_B        = 'hACE1,
    parameter bit               STOP_ON_FAIL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    clas_bist_engine_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [WIDTH-1:0]   vec_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_sel,
    output logic [WIDTH-1:0]   fail_result,
    output logic [2:0]         fsm_state
);
    localparam logic [WIDTH-1:0] POLY        = WIDTH'(32'h8020_0003);
    localparam int               SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] LAST_VEC    = WIDTH'(NUM_VECTORS - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic             done_q;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [SW-1:0]    settle_cnt;
    logic             captured;
    logic [WIDTH:0]   exp_sum;
    logic             mismatch;
    logic             last_vec;

    // Galois form, shifting right; the feedback mask carries the top tap.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    // Subtract is a + ~b + 1, so the carry out reads as "no borrow".
    assign exp_sum  = {1'b0, a_q} + {1'b0, (sel_q ? ~b_q : b_q)} + {{WIDTH{1'b0}}, sel_q};
    assign mismatch = (bus.dut_result != exp_sum[WIDTH-1:0]) || (bus.dut_c_out != exp_sum[WIDTH]);
    assign last_vec = (vec_count == LAST_VEC);

    assign bus.dut_a   = a_q;
    assign bus.dut_b   = b_q;
    assign bus.dut_sel = sel_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:       state_next = SETTLE;
            SETTLE:     if (settle_cnt == SETTLE_LAST) state_next = CHECK;
            CHECK: begin
                if ((STOP_ON_FAIL && mismatch) || (last_vec && sel_q)) state_next = DONE;
                else                                                    state_next = LOAD;
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == LOAD) || (state == SETTLE) || (state == CHECK);
        done      = done_q;
        pass      = done_q && (err_count == 16'd0);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= 1'b0;
            done_q      <= 1'b0;
            err_count   <= '0;
            vec_count   <= '0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_sel    <= 1'b0;
            fail_result <= '0;
            captured    <= 1'b0;
            settle_cnt  <= '0;
            lfsr_a      <= SEED_A;
            lfsr_b      <= SEED_B;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_count   <= '0;
                        vec_count   <= '0;
                        fail_a      <= '0;
                        fail_b      <= '0;
                        fail_sel    <= 1'b0;
                        fail_result <= '0;
                        captured    <= 1'b0;
                        done_q      <= 1'b0;
                        sel_q       <= 1'b0;
                        lfsr_a      <= SEED_A;
                        lfsr_b      <= SEED_B;
                    end
                end
                LOAD: begin
                    settle_cnt <= '0;
                    case (vec_count)
                        WIDTH'(0): begin a_q <= '0;       b_q <= '0;       end
                        WIDTH'(1): begin a_q <= '1;       b_q <= WIDTH'(1); end
                        WIDTH'(2): begin a_q <= '1;       b_q <= '1;       end
                        WIDTH'(3): begin a_q <= MSB_ONLY; b_q <= MSB_ONLY; end
                        default: begin
                            a_q    <= lfsr_a;
                            b_q    <= lfsr_b;
                            lfsr_a <= lfsr_step(lfsr_a);
                            lfsr_b <= lfsr_step(lfsr_b);
                        end
                    endcase
                end
                SETTLE: settle_cnt <= settle_cnt + SW'(1);
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (!captured) begin
                            captured    <= 1'b1;
                            fail_a      <= a_q;
                            fail_b      <= b_q;
                            fail_sel    <= sel_q;
                            fail_result <= bus.dut_result;
                        end
                    end
                    if (STOP_ON_FAIL && mismatch) begin
                        done_q <= 1'b1;
                    end else if (!last_vec) begin
                        vec_count <= vec_count + WIDTH'(1);
                    end else if (!sel_q) begin
                        // Subtract pass replays the identical operand sequence.
                        sel_q     <= 1'b1;
                        vec_count <= '0;
                        lfsr_a    <= SEED_A;
                        lfsr_b    <= SEED_B;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clas_bist_engine.sv
// Directed bench for clas_bist_engine: one instance against a correct adder
// model, two against a result-bit-0 stuck-at-1 model (with and without stop-on-fail).
module tb_clas_bist_engine;
  localparam int W = 32;
  localparam int NV = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_g = 1'b0;
  logic start_f = 1'b0;
  logic start_s = 1'b0;

  always #5 clk = ~clk;

  clas_bist_engine_if #(.WIDTH(W)) if_g ();
  clas_bist_engine_if #(.WIDTH(W)) if_f ();
  clas_bist_engine_if #(.WIDTH(W)) if_s ();

  // Unit-under-test models: a correct adder/subtractor and a faulty copy.
  logic [W:0] sum_g, sum_f, sum_s;
  assign sum_g = {1'b0, if_g.dut_a} + {1'b0, (if_g.dut_sel ? ~if_g.dut_b : if_g.dut_b)} + {{W{1'b0}}, if_g.dut_sel};
  assign sum_f = {1'b0, if_f.dut_a} + {1'b0, (if_f.dut_sel ? ~if_f.dut_b : if_f.dut_b)} + {{W{1'b0}}, if_f.dut_sel};
  assign sum_s = {1'b0, if_s.dut_a} + {1'b0, (if_s.dut_sel ? ~if_s.dut_b : if_s.dut_b)} + {{W{1'b0}}, if_s.dut_sel};
  assign if_g.dut_result = sum_g[W-1:0];
  assign if_g.dut_c_out  = sum_g[W];
  assign if_f.dut_result = sum_f[W-1:0] | W'(1);
  assign if_f.dut_c_out  = sum_f[W];
  assign if_s.dut_result = sum_s[W-1:0] | W'(1);
  assign if_s.dut_c_out  = sum_s[W];

  logic busy_g, done_g, pass_g, fs_g;
  logic [15:0] err_g;
  logic [W-1:0] vec_g, fa_g, fb_g, fr_g;
  logic [2:0] st_g;
  logic busy_f, done_f, pass_f, fs_f;
  logic [15:0] err_f;
  logic [W-1:0] vec_f, fa_f, fb_f, fr_f;
  logic [2:0] st_f;
  logic busy_s, done_s, pass_s, fs_s;
  logic [15:0] err_s;
  logic [W-1:0] vec_s, fa_s, fb_s, fr_s;
  logic [2:0] st_s;

  clas_bist_engine #(.WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_good (
    .clk(clk), .rst(rst), .start(start_g), .bus(if_g.master),
    .busy(busy_g), .done(done_g), .pass(pass_g), .err_count(err_g), .vec_count(vec_g),
    .fail_a(fa_g), .fail_b(fb_g), .fail_sel(fs_g), .fail_result(fr_g), .fsm_state(st_g));

  clas_bist_engine #(.WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b0)) u_flt (
    .clk(clk), .rst(rst), .start(start_f), .bus(if_f.master),
    .busy(busy_f), .done(done_f), .pass(pass_f), .err_count(err_f), .vec_count(vec_f),
    .fail_a(fa_f), .fail_b(fb_f), .fail_sel(fs_f), .fail_result(fr_f), .fsm_state(st_f));

  clas_bist_engine #(.WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(1), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start_s), .bus(if_s.master),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .vec_count(vec_s),
    .fail_a(fa_s), .fail_b(fb_s), .fail_sel(fs_s), .fail_result(fr_s), .fsm_state(st_s));

  // Operand sequence per vector index, hand-derived (LFSR right-shift Galois, mask 80200003).
  typedef struct {
    logic         sel;
    logic [W-1:0] vec;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t tbl[2*NV];
  logic [W-1:0] op_a[NV];
  logic [W-1:0] op_b[NV];

  int n_checks = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_good(input bit poke);
    int cycles;
    int k;
    cycles = 0;
    k = 0;
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    while (!done_g && cycles < 200) begin
      tick();
      cycles++;
      if (poke) start_g = (cycles == 5 || cycles == 20 || cycles == 47);
      if (st_g == 3'd3) begin
        if (k < 2*NV) begin
          check($sformatf("v%0d_a", k), if_g.dut_a, tbl[k].a);
          check($sformatf("v%0d_b", k), if_g.dut_b, tbl[k].b);
          check($sformatf("v%0d_sel", k), if_g.dut_sel, tbl[k].sel);
          check($sformatf("v%0d_idx", k), vec_g, tbl[k].vec);
        end
        k++;
      end
    end
    start_g = 1'b0;
    check("run_cycles", cycles, 48);
    check("check_states", k, 2*NV);
    check("good_done", done_g, 1);
    check("good_pass", pass_g, 1);
    check("good_err", err_g, 0);
    check("good_busy", busy_g, 0);
    check("good_state_done", st_g, 3'd4);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, st_g, 3'd0);
    check({tag, "_a"}, if_g.dut_a, 0);
    check({tag, "_b"}, if_g.dut_b, 0);
    check({tag, "_sel"}, if_g.dut_sel, 0);
    check({tag, "_busy"}, busy_g, 0);
    check({tag, "_done"}, done_g, 0);
    check({tag, "_pass"}, pass_g, 0);
    check({tag, "_err"}, err_g, 0);
    check({tag, "_vec"}, vec_g, 0);
    check({tag, "_fail"}, {fa_g, fb_g}, 0);
    check({tag, "_fail_sr"}, {fs_g, fr_g}, 0);
  endtask

  initial begin
    int cycles;
    op_a = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
    op_b = '{32'h0, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h0000ACE1, 32'h80205673, 32'hC0302B3A, 32'h6018159D};
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < NV; v++) begin
        tbl[p*NV+v].sel = (p == 1);
        tbl[p*NV+v].vec = W'(v);
        tbl[p*NV+v].a   = op_a[v];
        tbl[p*NV+v].b   = op_b[v];
      end
    end

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    check("reset_flt_state", st_f, 3'd0);
    check("reset_stop_state", st_s, 3'd0);
    rst = 1'b0;
    tick();

    // Full run on a correct unit, with start pulses while busy
    run_good(1'b1);

    // Stuck-at-1 result bit 0: every vector here expects bit 0 == 0
    start_f = 1'b1;
    start_s = 1'b1;
    tick();
    start_f = 1'b0;
    start_s = 1'b0;
    tick();
    tick();
    check("stop_done_early", done_s, 0);
    tick();
    check("stop_done", done_s, 1);
    check("stop_err", err_s, 1);
    check("stop_vec", vec_s, 0);
    check("stop_pass", pass_s, 0);
    check("stop_busy", busy_s, 0);
    check("stop_fail_ab", {fa_s, fb_s}, 0);
    check("stop_fail_sel", fs_s, 0);
    check("stop_fail_result", fr_s, 1);

    cycles = 3;
    while (!done_f && cycles < 200) begin
      tick();
      cycles++;
    end
    check("flt_cycles", cycles, 48);
    check("flt_err", err_f, 16);
    check("flt_pass", pass_f, 0);
    check("flt_vec", vec_f, NV - 1);
    check("flt_fail_ab", {fa_f, fb_f}, 0);
    check("flt_fail_sel", fs_f, 0);
    check("flt_fail_result", fr_f, 1);

    // Reset during SETTLE of subtract vector 5; start in the reset cycle is ignored
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    cycles = 0;
    while (!(st_g == 3'd2 && if_g.dut_sel && vec_g == 5) && cycles < 200) begin
      tick();
      cycles++;
    end
    check("reach_sub_v5_settle", (st_g == 3'd2 && if_g.dut_sel && vec_g == 5), 1);
    rst = 1'b1;
    start_g = 1'b1;
    tick();
    rst = 1'b0;
    start_g = 1'b0;
    check_zero("midrst");
    tick();
    check("midrst_stay_idle", st_g, 3'd0);

    // Fresh run restarts from vector 0 in add mode with seeded LFSRs
    run_good(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clas_bist_engine.md
Name: clas_bist_engine

Overview:
- Hardware self-test initiator for the 32-bit carry-look-ahead adder/subtractor: generates operand/mode vectors, drives the unit's a/b/sel inputs, samples result/c_out, and checks them against an internal behavioural reference.
- Replaces exhaustive simulation sweeps with a bounded, synthesizable on-chip check: directed corner vectors, then LFSR-random vectors, run in an add pass followed by a subtract pass.
- Sits beside the adder/subtractor and is controlled by a start/done handshake from the test controller.

Parameters:
- WIDTH, 32, operand width; must match the unit under test.
- NUM_VECTORS, 1024, vectors per pass, including the 4 corner vectors; minimum 4.
- SETTLE_CYCLES, 1, cycles operands are held before the result is sampled; minimum 1.
- SEED_A, 32'h1, LFSR seed for operand a; must be nonzero.
- SEED_B, 32'hACE1, LFSR seed for operand b; must be nonzero.
- STOP_ON_FAIL, 0, when 1 the run ends at the first mismatch.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- dut_a  out  WIDTH  operand a to the unit.
- dut_b  out  WIDTH  operand b to the unit.
- dut_sel  out  1  0 selects add, 1 selects subtract.
- dut_result  in  WIDTH  result from the unit.
- dut_c_out  in  1  carry out from the unit.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start or rst.
- pass  out  1  equals done and err_count==0.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- vec_count  out  WIDTH  index of the current vector within the pass.
- fail_a, fail_b  out  WIDTH  operands of the first failing vector.
- fail_sel  out  1  mode of the first failing vector.
- fail_result  out  WIDTH  result received for the first failing vector.

Behaviour:
- Reset (any cycle, including mid-run):
  - FSM returns to IDLE.
  - All outputs go to 0.
  - LFSRs reload SEED_A and SEED_B.
  - The first-fail capture is cleared.
- FSM states: IDLE, LOAD, SETTLE, CHECK, DONE.
  - IDLE/DONE -> LOAD on start. Entering LOAD clears err_count, vec_count, capture and done, sets dut_sel=0, and reloads the LFSRs.
  - LOAD: registers the next operands onto dut_a/dut_b, then -> SETTLE with the settle counter at 0.
  - SETTLE: counts SETTLE_CYCLES cycles, then -> CHECK.
  - CHECK: compares and updates the counters. Next state:
    - vec_count < NUM_VECTORS-1: LOAD with vec_count+1.
    - Last vector with dut_sel=0: dut_sel<=1, vec_count<=0, LFSRs reseeded, then LOAD.
    - Last vector with dut_sel=1: DONE.
    - STOP_ON_FAIL=1 and a mismatch: DONE immediately.
- busy=1 in LOAD, SETTLE and CHECK.
- start while busy is ignored.
- Per-vector latency is SETTLE_CYCLES+2 cycles. A full run takes 2*NUM_VECTORS*(SETTLE_CYCLES+2) cycles from the start edge to done=1.
- Operands are ordered by vec_count, identically in both passes:
  - 0: a=0, b=0.
  - 1: a=all-ones, b=1.
  - 2: a=all-ones, b=all-ones.
  - 3: a=MSB-only, b=MSB-only.
  - 4 and above: a and b are the current Galois LFSR states. Polynomial is 32'h80200003. Both LFSRs step once per LOAD from index 4 onward.
- Reference model, computed at WIDTH+1 bits: {exp_c, exp_r} = a + (sel ? ~b : b) + sel.
  - Subtract carry is therefore no-borrow, i.e. 1 when a >= b unsigned.
  - Results wrap modulo 2^WIDTH.
- Mismatch is defined as (dut_result != exp_r) or (dut_c_out != exp_c).
  - Each mismatch increments err_count, saturating at 16'hFFFF.
  - Only the first mismatch loads fail_a, fail_b, fail_sel and fail_result.
- A start arriving in the same cycle as rst is ignored; reset wins.

Test Plan:
- Correct adder model, NUM_VECTORS=8, SETTLE_CYCLES=1, pulse start -> done=1 after exactly 48 cycles; pass=1, err_count=0, busy=0 afterward.
- Add pass vector 1 (a=FFFFFFFF, b=1) -> the CHECK-cycle reference is result 0, c_out 1. Subtract pass vector 2 (FFFFFFFF-FFFFFFFF) -> result 0, c_out 1.
- Fault model forcing result bit 0 stuck-at-1, STOP_ON_FAIL=0 -> mismatches counted on every vector whose expected bit 0 is 0.
  - Vector 0: fail_a=0, fail_b=0, fail_sel=0, fail_result=1.
  - pass=0 at done.
- Same fault with STOP_ON_FAIL=1 -> done asserts 1 cycle after the first CHECK; err_count=1; vec_count=0.
- Assert rst during SETTLE of subtract vector 5 -> the next cycle has all outputs 0 and the FSM in IDLE. A following start runs from vector 0 with dut_sel=0 and LFSRs at their seeds.
- Pulse start while busy -> no effect: vec_count progression and total cycle count are unchanged.
